// File: rtl/piso_if.sv
// piso_if: parallel word in, mode select and serial bit out.
// The master drives control and in; the shift register drives out.
interface piso_if #(
    parameter int N = 8
);
    logic         control;
    logic [N-1:0] in;
    logic         out;

    modport master (
        output control,
        output in,
        input  out
    );

    modport slave (
        input  control,
        input  in,
        output out
    );
endinterface

// File: rtl/piso.sv
// piso: parallel-in serial-out shift register.
// Loads a word on control=0, shifts one position per clock on control=1.
module piso #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst,
    piso_if.slave bus
);

    localparam int HEAD = MSB_FIRST ? N - 1 : 0;

    logic [N-1:0] sr_q;
    logic [N-1:0] sr_d;

    // next shift-register contents: load the word or shift with zero fill
    always_comb begin
        sr_d = sr_q;
        if (!bus.control) begin
            sr_d = bus.in;
        end else if (MSB_FIRST) begin
            sr_d = {sr_q[N-2:0], 1'b0};
        end else begin
            sr_d = {1'b0, sr_q[N-1:1]};
        end
    end

    // shift-register state, cleared immediately by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bus.out = sr_q[HEAD];

endmodule

// File: tb/tb_piso.sv
// tb_piso: scoreboard bench for piso, MSB-first and LSB-first at N=8.
// Both instances see identical stimulus; expected bits are queued per edge.
module tb_piso;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic q_m[$];
    logic q_l[$];

    piso_if #(.N(8)) m_if ();
    piso_if #(.N(8)) l_if ();

    piso #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst_n),
        .bus (m_if.slave)
    );

    piso #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst_n),
        .bus (l_if.slave)
    );

    always #5 clk = ~clk;

    // Bit k of the serial stream after loading w (k=0 is the load cycle).
    function automatic logic exp_bit(input logic [7:0] w, input int k,
                                     input bit msb);
        if (k >= 8) return 1'b0;
        return msb ? w[7-k] : w[k];
    endfunction

    // One clock: drive at negedge, queue expectations, settle after posedge.
    task automatic cycle(input logic c, input logic [7:0] w,
                         input logic em, input logic el);
        @(negedge clk);
        m_if.control = c;
        m_if.in      = w;
        l_if.control = c;
        l_if.in      = w;
        q_m.push_back(em);
        q_l.push_back(el);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic em, el;
        #1;
        checks++;
        if (m_if.out !== 1'b0 || l_if.out !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got %b/%b exp 0/0", m_if.out, l_if.out);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(i[0], 8'hFF, 1'b0, 1'b0);
            em = q_m.pop_front();
            el = q_l.pop_front();
            checks++;
            if (m_if.out !== em || l_if.out !== el) begin
                errors++;
                $display("FAIL reset_hold i=%0d got %b/%b exp %b/%b",
                         i, m_if.out, l_if.out, em, el);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        em = q_m.pop_front();
        el = q_l.pop_front();
        checks++;
        if (m_if.out !== em || l_if.out !== el) begin
            errors++;
            $display("FAIL reset_first_shift got %b/%b exp %b/%b",
                     m_if.out, l_if.out, em, el);
        end
        cycle(1'b0, 8'hFF, 1'b1, 1'b1);
        em = q_m.pop_front();
        el = q_l.pop_front();
        checks++;
        if (m_if.out !== em || l_if.out !== el) begin
            errors++;
            $display("FAIL reset_load got %b/%b exp %b/%b",
                     m_if.out, l_if.out, em, el);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_if.out !== 1'b0 || l_if.out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got %b/%b exp 0/0",
                     m_if.out, l_if.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load(input logic [7:0] w, input int shifts,
                             input string name);
        logic em, el;
        for (int k = 0; k <= shifts; k++) begin
            cycle(k != 0, w, exp_bit(w, k, 1'b1), exp_bit(w, k, 1'b0));
            em = q_m.pop_front();
            el = q_l.pop_front();
            checks++;
            if (m_if.out !== em) begin
                errors++;
                $display("FAIL %s_msb w=%h k=%0d got %b exp %b",
                         name, w, k, m_if.out, em);
            end
            checks++;
            if (l_if.out !== el) begin
                errors++;
                $display("FAIL %s_lsb w=%h k=%0d got %b exp %b",
                         name, w, k, l_if.out, el);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3] = '{8'h2E, 8'h0A, 8'h80};
        foreach (words[i]) test_load(words[i], 8, "b2b");
    endtask

    task automatic test_reload();
        logic em, el;
        logic [7:0] w;
        for (int k = 0; k < 4; k++) begin
            cycle(k != 0, 8'hFF, exp_bit(8'hFF, k, 1'b1),
                  exp_bit(8'hFF, k, 1'b0));
            em = q_m.pop_front();
            el = q_l.pop_front();
            checks++;
            if (m_if.out !== em || l_if.out !== el) begin
                errors++;
                $display("FAIL reload_pre k=%0d got %b/%b exp %b/%b",
                         k, m_if.out, l_if.out, em, el);
            end
        end
        w = 8'h01;
        for (int k = 0; k < 8; k++) begin
            cycle(k != 0, w, exp_bit(w, k, 1'b1), exp_bit(w, k, 1'b0));
            em = q_m.pop_front();
            el = q_l.pop_front();
            checks++;
            if (m_if.out !== em || l_if.out !== el) begin
                errors++;
                $display("FAIL reload_post k=%0d got %b/%b exp %b/%b",
                         k, m_if.out, l_if.out, em, el);
            end
        end
    endtask

    task automatic test_hold_load();
        logic em, el;
        logic [7:0] w;
        for (int i = 0; i < 6; i++) begin
            w = 8'($urandom);
            cycle(1'b0, w, w[7], w[0]);
            em = q_m.pop_front();
            el = q_l.pop_front();
            checks++;
            if (m_if.out !== em || l_if.out !== el) begin
                errors++;
                $display("FAIL hold_load w=%h got %b/%b exp %b/%b",
                         w, m_if.out, l_if.out, em, el);
            end
        end
    endtask

    initial begin
        m_if.control = 1'b0;
        m_if.in      = 8'h00;
        l_if.control = 1'b0;
        l_if.in      = 8'h00;
        test_reset();
        test_load(8'hDD, 8, "load");
        test_back_to_back();
        test_reload();
        test_load(8'hA5, 12, "overshift");
        test_hold_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
